// File: rtl/shift_seq_ctrl.sv
// Purpose: sequences a shift datapath through a small program of {count, color, sel} steps.
// Latency: start sampled at edge t -> clear/busy after t, datapath enable after t+1; all outputs registered.
// Backpressure: i_hold pauses the running step (counter preserved); i_stop aborts to IDLE from any state.
module shift_seq_ctrl #(
  parameter int NB_SW   = 4,
  parameter int NB_SEL  = 2,
  parameter int N_STEPS = 4,
  parameter int NB_CNT  = 4,
  localparam int NB_ADDR = (N_STEPS > 1) ? $clog2(N_STEPS) : 1,
  localparam int NB_DATA = NB_CNT + 1 + NB_SEL
) (
  input  logic               clock,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic               i_stop,
  input  logic               i_hold,
  input  logic               i_loop,
  input  logic               i_prog_we,
  input  logic [NB_ADDR-1:0] i_prog_addr,
  input  logic [NB_DATA-1:0] i_prog_data,
  input  logic               i_shift_tick,
  output logic [NB_SW-1:0]   o_sw,
  output logic               o_sr_clr,
  output logic               o_busy,
  output logic [NB_ADDR-1:0] o_step,
  output logic               o_done
);

  localparam logic [NB_ADDR-1:0] LAST_STEP = NB_ADDR'(N_STEPS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_PAUSE,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [NB_DATA-1:0]  mem_q [N_STEPS];
  logic [NB_DATA-1:0]  mem_d [N_STEPS];
  logic [NB_ADDR-1:0]  step_q, step_d;
  logic [NB_CNT-1:0]   cnt_q, cnt_d;
  logic [NB_CNT-1:0]   act_cnt_q, act_cnt_d;
  logic                act_col_q, act_col_d;
  logic [NB_SEL-1:0]   act_sel_q, act_sel_d;
  // Set once any step of the current pass had a non-zero count; gates looping.
  logic                pass_nz_q, pass_nz_d;
  logic [NB_SW-1:0]    sw_q, sw_d;
  logic                sr_clr_q, sr_clr_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [NB_DATA-1:0]  entry;
  logic [NB_CNT-1:0]   ent_cnt;
  logic                ent_col;
  logic [NB_SEL-1:0]   ent_sel;
  logic                step_cmp;

  // Next-state, program memory write and registered-output computation.
  always_comb begin
    entry   = mem_q[step_q];
    ent_cnt = entry[NB_DATA-1 -: NB_CNT];
    ent_col = entry[NB_SEL];
    ent_sel = entry[NB_SEL-1:0];

    state_d   = state_q;
    mem_d     = mem_q;
    step_d    = step_q;
    cnt_d     = cnt_q;
    act_cnt_d = act_cnt_q;
    act_col_d = act_col_q;
    act_sel_d = act_sel_q;
    pass_nz_d = pass_nz_q;
    sr_clr_d  = 1'b0;
    step_cmp  = 1'b0;

    // The program can only be changed while the sequencer is parked.
    if (state_q == S_IDLE && i_prog_we && (int'(i_prog_addr) < N_STEPS)) begin
      mem_d[i_prog_addr] = i_prog_data;
    end

    case (state_q)
      S_IDLE: begin
        if (i_start && !i_stop) begin
          state_d   = S_LOAD;
          step_d    = '0;
          pass_nz_d = 1'b0;
          sr_clr_d  = 1'b1;
        end
      end
      S_LOAD: begin
        act_cnt_d = ent_cnt;
        act_col_d = ent_col;
        act_sel_d = ent_sel;
        cnt_d     = '0;
        if (ent_cnt != '0) begin
          pass_nz_d = 1'b1;
          state_d   = S_RUN;
        end else begin
          // Zero-count step is skipped and completes immediately.
          step_cmp = 1'b1;
        end
      end
      S_RUN: begin
        if (i_shift_tick) begin
          cnt_d = cnt_q + NB_CNT'(1);
          if (cnt_q == act_cnt_q - NB_CNT'(1)) begin
            step_cmp = 1'b1;
          end
        end
        if (!step_cmp && i_hold) begin
          state_d = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (!i_hold) begin
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (step_cmp) begin
      if (step_q != LAST_STEP) begin
        step_d  = step_q + NB_ADDR'(1);
        state_d = S_LOAD;
      end else if (i_loop && pass_nz_q) begin
        step_d    = '0;
        pass_nz_d = 1'b0;
        state_d   = S_LOAD;
      end else begin
        state_d = S_DONE;
      end
    end

    // Abort wins over everything else outside IDLE.
    if (state_q != S_IDLE && i_stop) begin
      state_d = S_IDLE;
    end

    if (state_d == S_IDLE) begin
      step_d = '0;
    end

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
    sw_d   = '0;
    if (state_d == S_RUN || state_d == S_PAUSE) begin
      sw_d[0]          = (state_d == S_RUN);
      sw_d[NB_SEL:1]   = act_sel_d;
      sw_d[NB_SEL+1]   = act_col_d;
    end
  end

  // State, program memory and output registers; reset clears everything including the program.
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q   <= S_IDLE;
      for (int i = 0; i < N_STEPS; i++) begin
        mem_q[i] <= '0;
      end
      step_q    <= '0;
      cnt_q     <= '0;
      act_cnt_q <= '0;
      act_col_q <= 1'b0;
      act_sel_q <= '0;
      pass_nz_q <= 1'b0;
      sw_q      <= '0;
      sr_clr_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mem_q     <= mem_d;
      step_q    <= step_d;
      cnt_q     <= cnt_d;
      act_cnt_q <= act_cnt_d;
      act_col_q <= act_col_d;
      act_sel_q <= act_sel_d;
      pass_nz_q <= pass_nz_d;
      sw_q      <= sw_d;
      sr_clr_q  <= sr_clr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign o_sw     = sw_q;
  assign o_sr_clr = sr_clr_q;
  assign o_busy   = busy_q;
  assign o_step   = step_q;
  assign o_done   = done_q;

endmodule

// File: doc/shift_seq_ctrl.md
SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

Interface
REQ-001 Parameters SHALL be: NB_SW, default 4, width of switch-format control word; NB_SEL, default 2, limit-select width; N_STEPS, default 4, program depth; NB_CNT, default 4, shift-count width per step.
REQ-002 clock  in  1  system clock; all state SHALL update on its rising edge.
REQ-003 i_reset  in  1  reset, asynchronous, active-low.
REQ-004 i_start  in  1  level; sampled in IDLE only, starts program execution.
REQ-005 i_stop  in  1  abort; returns to IDLE from any state.
REQ-006 i_hold  in  1  pause request while running.
REQ-007 i_loop  in  1  restart at step 0 after the last step instead of finishing.
REQ-008 i_prog_we  in  1  program write strobe.
REQ-009 i_prog_addr  in  log2(N_STEPS)  program entry address.
REQ-010 i_prog_data  in  NB_CNT+1+NB_SEL  entry {count, color, sel}.
REQ-011 i_shift_tick  in  1  one-cycle pulse from the shift datapath on each shift event (counter reached limit).
REQ-012 o_sw  out  NB_SW  datapath control word: bit0 enable, bits[2:1] limit select, bit3 color.
REQ-013 o_sr_clr  out  1  one-cycle datapath clear request.
REQ-014 o_busy  out  1  high in every state except IDLE.
REQ-015 o_step  out  log2(N_STEPS)  index of current step.
REQ-016 o_done  out  1  one-cycle completion pulse.

Function
REQ-017 States SHALL be IDLE, LOAD, RUN, PAUSE, DONE; all outputs registered.
REQ-018 Program memory SHALL hold N_STEPS entries; writes accepted only in IDLE, ignored (memory unchanged) otherwise.
REQ-019 IDLE: o_sw=0; i_start=1 -> LOAD with o_step=0, o_sr_clr=1 for that single LOAD cycle (first LOAD of a run only).
REQ-020 LOAD (one cycle): latch entry[o_step] into active sel/color/count, clear shift counter; count!=0 -> RUN; count==0 -> step skipped, treated as step completion (REQ-023).
REQ-021 RUN: o_sw={color, sel, 1'b1}; each i_shift_tick increments shift counter (NB_CNT bits).
REQ-022 Step complete SHALL be when a tick arrives with shift counter == count-1.
REQ-023 Step completion: o_step<N_STEPS-1 -> o_step+1, LOAD; last step and i_loop=1 and at least one step of the pass had count!=0 -> o_step=0, LOAD (no o_sr_clr); otherwise -> DONE.
REQ-024 RUN with i_hold=1 and no step completion -> PAUSE; a tick in the same cycle SHALL still be counted; step completion has priority over hold.
REQ-025 PAUSE: o_sw={color, sel, 1'b0}; ticks ignored; i_hold=0 -> RUN next cycle with counter preserved.
REQ-026 DONE (one cycle): o_done=1, o_sw=0 -> IDLE.
REQ-027 i_stop=1 in LOAD/RUN/PAUSE/DONE SHALL force IDLE next cycle, o_sw=0, no o_done; priority stop > step completion > hold.
REQ-028 Latency: i_start sampled at edge t -> o_sr_clr/o_busy high after t, o_sw enable high after edge t+1.
REQ-029 All-zero program SHALL skip N_STEPS LOAD cycles then DONE, even with i_loop=1.

Reset
REQ-030 While i_reset=0: state IDLE, o_sw=0, o_sr_clr=0, o_busy=0, o_step=0, o_done=0, counters and program memory cleared; reset mid-run SHALL abort immediately with no o_done.

Verification
REQ-031 Program entries {2,0,01},{1,1,11},{0,0,00},{3,0,10}, loop=0, start -> o_sr_clr one cycle; o_sw=0x3 for 2 ticks, 0xF for 1, step 2 skipped, 0x5 for 3 ticks; o_done one cycle; IDLE.
REQ-032 Same program, i_hold=1 after first tick of step 0 -> o_sw=0x2, 5 ticks ignored; hold released -> one more tick completes step 0.
REQ-033 loop=1 -> after step 3 o_step returns to 0, no o_sr_clr, no o_done; i_stop -> IDLE next cycle, o_sw=0, o_done never asserted.
REQ-034 All-zero program, loop=1, start -> 4 LOAD cycles, o_done, IDLE; o_sw enable never set.
REQ-035 Write to entry 0 while RUN -> ignored; subsequent run uses original entry.
REQ-036 i_reset low during RUN step 1 -> all outputs 0 asynchronously; after release, start runs from step 0 with memory cleared (all-zero behaviour).
